ms_timebase_gen: RTL and testbench

MS_TIMEBASE_GEN -- requirements
Module: ms_timebase_gen

---
 rtl/ms_timebase_gen.sv | 140 ++++++++++++++
 tb/tb_ms_timebase_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ms_timebase_gen.sv
// Millisecond timebase: divides sb_clk into a 50% duty ms_clk with a rise tick, an elapsed counter and a
// runtime-reloadable half-period. Optional sticky timeout comparator is built only with `define MS_TIMEOUT_EN.
`timescale 1ns/1ps
module ms_timebase_gen #(
   parameter int CNT_W        = 16,
   parameter int DIV_HALF_RST = 500,
   parameter int ELAPSED_W    = 16
) (
   input  logic                 sb_clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [CNT_W-1:0]     div_half,
   input  logic                 div_load,
   output logic                 div_ack,
   output logic                 ms_clk,
   output logic                 ms_tick,
   output logic [ELAPSED_W-1:0] ms_count,
   input  logic                 cnt_clr,
   input  logic [ELAPSED_W-1:0] timeout_val,
   output logic                 timeout
);

   typedef enum logic [1:0] {STOP, RUN, RELOAD} state_t;

   localparam logic [CNT_W-1:0]     DIV_RST = CNT_W'(DIV_HALF_RST);
   localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
   localparam logic [ELAPSED_W-1:0] EL_ONE  = ELAPSED_W'(1);

   state_t                state;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      div_q, div_d;
   logic [CNT_W-1:0]      div_pend_q, div_pend_d;
   logic                  pend_flag_q, pend_flag_d;
   logic                  ms_clk_q, ms_clk_d;
   logic                  ms_tick_q, ms_tick_d;
   logic                  div_ack_q, div_ack_d;
   logic [ELAPSED_W-1:0]  ms_count_q, ms_count_d;
   logic                  boundary;
   logic                  load_ok;

   // Mode is decoded from en directly so counting starts on the first edge after reset release.
   always_comb begin
      if (!en)              state = STOP;
      else if (pend_flag_q) state = RELOAD;
      else                  state = RUN;
   end

   assign load_ok  = div_load && (div_half != '0);
   assign boundary = (state != STOP) && (cnt_q == div_q - CNT_ONE);

   always_comb begin
      cnt_d       = cnt_q;
      div_d       = div_q;
      div_pend_d  = div_pend_q;
      pend_flag_d = pend_flag_q;
      ms_clk_d    = ms_clk_q;
      ms_tick_d   = 1'b0;
      div_ack_d   = 1'b0;
      ms_count_d  = ms_count_q;

      case (state)
         RUN, RELOAD: begin
            if (boundary) begin
               cnt_d     = '0;
               ms_clk_d  = ~ms_clk_q;
               ms_tick_d = ~ms_clk_q;
               if (state == RELOAD) begin
                  div_d       = div_pend_q;
                  pend_flag_d = 1'b0;
                  div_ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: ;
      endcase

      // A load landing on a boundary re-arms the pending slot, so it takes effect one boundary later.
      if (load_ok) begin
         div_pend_d  = div_half;
         pend_flag_d = 1'b1;
      end

      if (cnt_clr)
         ms_count_d = '0;
      else if (ms_tick_q && (ms_count_q != '1))
         ms_count_d = ms_count_q + EL_ONE;
   end

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         div_q       <= DIV_RST;
         div_pend_q  <= '0;
         pend_flag_q <= 1'b0;
         ms_clk_q    <= 1'b0;
         ms_tick_q   <= 1'b0;
         div_ack_q   <= 1'b0;
         ms_count_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         div_pend_q  <= div_pend_d;
         pend_flag_q <= pend_flag_d;
         ms_clk_q    <= ms_clk_d;
         ms_tick_q   <= ms_tick_d;
         div_ack_q   <= div_ack_d;
         ms_count_q  <= ms_count_d;
      end
   end

   assign ms_clk   = ms_clk_q;
   assign ms_tick  = ms_tick_q;
   assign div_ack  = div_ack_q;
   assign ms_count = ms_count_q;

`ifdef MS_TIMEOUT_EN
   logic timeout_q;
   logic to_hit;

   assign to_hit = (timeout_val != '0) && (ms_count_q >= timeout_val);

   always_ff @(posedge sb_clk or negedge rst) begin
      if (!rst)
         timeout_q <= 1'b0;
      else if (cnt_clr || (timeout_val == '0))
         timeout_q <= 1'b0;
      else if (to_hit)
         timeout_q <= 1'b1;
   end

   assign timeout = timeout_q && (timeout_val != '0);
`else
   logic unused_timeout_val;
   assign unused_timeout_val = ^timeout_val;
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_ms_timebase_gen.sv
// Directed bench for ms_timebase_gen with DIV_HALF_RST=3 and a 4-bit elapsed counter.
`timescale 1ns/1ps
module tb_ms_timebase_gen;

   localparam int CNT_W = 16;
   localparam int EW    = 4;
`ifdef MS_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic            sb_clk = 1'b0;
   logic            rst;
   logic            en;
   logic [CNT_W-1:0] div_half;
   logic            div_load;
   logic            div_ack;
   logic            ms_clk;
   logic            ms_tick;
   logic [EW-1:0]   ms_count;
   logic            cnt_clr;
   logic [EW-1:0]   timeout_val;
   logic            timeout;

   int n_tests = 0;
   int n_fail  = 0;

   ms_timebase_gen #(.CNT_W(CNT_W), .DIV_HALF_RST(3), .ELAPSED_W(EW)) dut (
      .sb_clk(sb_clk), .rst(rst), .en(en), .div_half(div_half), .div_load(div_load),
      .div_ack(div_ack), .ms_clk(ms_clk), .ms_tick(ms_tick), .ms_count(ms_count),
      .cnt_clr(cnt_clr), .timeout_val(timeout_val), .timeout(timeout)
   );

   always #5 sb_clk = ~sb_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sb_clk);
      #1;
   endtask

   // Runs until ms_clk changes level (bounded); optionally pulses div_load before edge ld_at.
   task automatic half(input int ld_at, input logic [CNT_W-1:0] ld_val, output int n, output int acks);
      logic lvl;
      lvl  = ms_clk;
      n    = 0;
      acks = 0;
      while (n < 64) begin
         if (n + 1 == ld_at) begin
            div_load = 1'b1;
            div_half = ld_val;
         end
         step();
         div_load = 1'b0;
         n++;
         acks += int'(div_ack);
         if (ms_clk != lvl) break;
      end
   endtask

   task automatic chk_half(input string tag, input int ld_at, input logic [CNT_W-1:0] ld_val,
                           input int exp_n, input int exp_acks);
      int n, a;
      half(ld_at, ld_val, n, a);
      chk({tag, "_len"}, 32'(n), 32'(exp_n));
      chk({tag, "_ack"}, 32'(a), 32'(exp_acks));
   endtask

   initial begin
      int n, a, i;
      rst = 1'b1; en = 1'b1; div_half = '0; div_load = 1'b0; cnt_clr = 1'b0; timeout_val = '0;
      #2 rst = 1'b0;
      #15;
      chk("rst_clk",   32'(ms_clk),   32'd0);
      chk("rst_tick",  32'(ms_tick),  32'd0);
      chk("rst_ack",   32'(div_ack),  32'd0);
      chk("rst_count", 32'(ms_count), 32'd0);
      chk("rst_to",    32'(timeout),  32'd0);
      @(negedge sb_clk) rst = 1'b1;

      // Edges 1..9 after release: rise at 3, fall at 6, rise at 9.
      for (int e = 1; e <= 9; e++) begin
         step();
         chk($sformatf("e%0d_clk", e),  32'(ms_clk),  32'((e >= 3 && e < 6) || e >= 9));
         chk($sformatf("e%0d_tick", e), 32'(ms_tick), 32'(e == 3 || e == 9));
      end
      chk("e9_count", 32'(ms_count), 32'd1);

      // Edge 10 leaves cnt=1; freeze for 10 cycles, the high half still needs two enabled edges.
      step();
      en = 1'b0;
      repeat (10) begin
         step();
         chk("stop_clk",  32'(ms_clk),  32'd1);
         chk("stop_tick", 32'(ms_tick), 32'd0);
      end
      chk("stop_count", 32'(ms_count), 32'd2);
      en = 1'b1;
      step();
      chk("resume1_clk", 32'(ms_clk), 32'd1);
      step();
      chk("resume2_clk", 32'(ms_clk), 32'd0);

      chk_half("ld5",      2, 16'd5, 3, 1);
      chk_half("run5",     0, 16'd0, 5, 0);
      chk_half("ld0",      2, 16'd0, 5, 0);
      chk_half("ld_bnd",   5, 16'd4, 5, 0);
      chk_half("ld_over",  1, 16'd3, 5, 1);
      chk_half("run3",     0, 16'd0, 3, 0);
      chk("count5", 32'(ms_count), 32'd5);

      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr", 32'(ms_count), 32'd0);

      timeout_val = 4'd4;
      for (i = 0; i < 400 && ms_count != 4'd4; i++) step();
      chk("to_sync", 32'(ms_count), 32'd4);
      chk("to_pre",  32'(timeout),  32'd0);
      step();
      chk("to_set",  32'(timeout),  32'(TO_EN));
      repeat (12) half(0, '0, n, a);
      chk("to_sticky", 32'(timeout), 32'(TO_EN));

      for (i = 0; i < 64 && ms_tick != 1'b1; i++) step();
      chk("tick_sync", 32'(ms_tick), 32'd1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_tick", 32'(ms_count), 32'd0);
      chk("to_clr",   32'(timeout),  32'd0);

      timeout_val = '0;
      repeat (44) half(0, '0, n, a);
      chk("sat",     32'(ms_count), 32'd15);
      chk("to_zero", 32'(timeout),  32'd0);

      div_load = 1'b1;
      div_half = 16'd7;
      step();
      div_load = 1'b0;
      @(negedge sb_clk) rst = 1'b0;
      #2;
      chk("rst2_clk",   32'(ms_clk),   32'd0);
      chk("rst2_tick",  32'(ms_tick),  32'd0);
      chk("rst2_ack",   32'(div_ack),  32'd0);
      chk("rst2_count", 32'(ms_count), 32'd0);
      chk("rst2_to",    32'(timeout),  32'd0);
      @(negedge sb_clk) rst = 1'b1;
      chk_half("post_rst_a", 0, 16'd0, 3, 0);
      chk_half("post_rst_b", 0, 16'd0, 3, 0);
      chk_half("post_rst_c", 0, 16'd0, 3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
